// File: rtl/burst_pkg.sv
// Shared types and helpers for the burst address generator.
package burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_mode_e;

  function automatic logic is_pow2(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/burst_addr_step.sv
// Combinational next-beat address and request legality check.
module burst_addr_step
  import burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned STRIDE_LEN    = 4,
  parameter int unsigned ADDR_MAX      = 2**ADDR_WIDTH-1,
  parameter int unsigned LEN_W         = $clog2(MAX_BURST_LEN)+1
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [LEN_W-1:0]      cur_len,
  input  logic [1:0]            cur_mode,
  input  logic [STRIDE_LEN-1:0] cur_stride,
  output logic [ADDR_WIDTH-1:0] next_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic [LEN_W-1:0]      chk_len,
  input  logic [1:0]            chk_mode,
  input  logic [STRIDE_LEN-1:0] chk_stride,
  output logic                  chk_legal
);

  // Wide enough that no span or window product can wrap.
  localparam int unsigned CW = ADDR_WIDTH + STRIDE_LEN + LEN_W;

  logic [CW-1:0]         cur_win;
  logic [ADDR_WIDTH-1:0] win_mask;
  logic [ADDR_WIDTH-1:0] stride_ext;
  logic [CW-1:0]         ca, cl, cs;

  always_comb begin
    cur_win    = CW'(cur_len) * CW'(cur_stride);
    win_mask   = ADDR_WIDTH'(cur_win - CW'(1));
    stride_ext = ADDR_WIDTH'(cur_stride);
    next_addr  = cur_addr;
    case (burst_mode_e'(cur_mode))
      BURST_INCR: next_addr = cur_addr + stride_ext;
      BURST_WRAP: next_addr = (cur_addr & ~win_mask) | ((cur_addr + stride_ext) & win_mask);
      default:    next_addr = cur_addr;
    endcase
  end

  always_comb begin
    ca        = CW'(chk_addr);
    cl        = CW'(chk_len);
    cs        = CW'(chk_stride);
    chk_legal = 1'b1;
    if (cl == '0 || cl > CW'(MAX_BURST_LEN)) chk_legal = 1'b0;
    case (burst_mode_e'(chk_mode))
      BURST_FIXED: ;
      BURST_INCR: begin
        if (ca + (cl - CW'(1)) * cs > CW'(ADDR_MAX)) chk_legal = 1'b0;
      end
      BURST_WRAP: begin
        if (!is_pow2(64'(cl)) || !is_pow2(64'(cs)) ||
            (cl * cs > CW'(ADDR_MAX) + CW'(1))) chk_legal = 1'b0;
      end
      default: chk_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: one request per handshake, one SRAM address per beat.
// Optional debug counters enabled by defining BURST_ADDR_GEN_DBG_CNT_EN.
module burst_addr_gen
  import burst_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH    = 8,
  parameter  int unsigned MAX_BURST_LEN = 16,
  parameter  int unsigned STRIDE_LEN    = 4,
  parameter  int unsigned ADDR_MAX      = 2**ADDR_WIDTH-1,
  localparam int unsigned LEN_W         = $clog2(MAX_BURST_LEN)+1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [1:0]            req_mode,
  input  logic [STRIDE_LEN-1:0] req_stride,
  input  logic                  abort,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic                  beat_last,
  output logic [LEN_W-1:0]      beat_idx,
  output logic                  busy,
  output logic                  req_err
`ifdef BURST_ADDR_GEN_DBG_CNT_EN
  ,
  output logic [15:0]           dbg_burst_cnt,
  output logic [7:0]            dbg_err_cnt
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  alive_q, alive_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [LEN_W-1:0]      len_q, len_d, idx_q, idx_d;
  logic [1:0]            mode_q, mode_d;
  logic [STRIDE_LEN-1:0] stride_q, stride_d;
  logic                  err_q, err_d;
  logic                  req_legal, accept, in_burst, is_last, xfer;

  burst_addr_step #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .STRIDE_LEN   (STRIDE_LEN),
    .ADDR_MAX     (ADDR_MAX),
    .LEN_W        (LEN_W)
  ) u_step (
    .cur_addr  (addr_q),
    .cur_len   (len_q),
    .cur_mode  (mode_q),
    .cur_stride(stride_q),
    .next_addr (next_addr),
    .chk_addr  (req_addr),
    .chk_len   (req_len),
    .chk_mode  (req_mode),
    .chk_stride(req_stride),
    .chk_legal (req_legal)
  );

  // alive_q keeps req_ready low until the first clock after reset release.
  always_comb begin
    in_burst = (state_q == S_BURST);
    accept   = req_valid && alive_q && (state_q == S_IDLE);
    is_last  = in_burst && (idx_q == len_q - LEN_W'(1));
    xfer     = in_burst && beat_ready && !abort;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && req_legal) state_d = S_BURST;
      S_BURST: if (abort || (xfer && is_last)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alive_d  = 1'b1;
    addr_d   = addr_q;
    len_d    = len_q;
    mode_d   = mode_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    err_d    = accept && !req_legal;
    if (accept) begin
      addr_d   = req_addr;
      len_d    = req_len;
      mode_d   = req_mode;
      stride_d = req_stride;
      idx_d    = '0;
    end else if (xfer) begin
      addr_d = next_addr;
      idx_d  = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alive_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      alive_q  <= alive_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    req_ready  = alive_q && (state_q == S_IDLE);
    busy       = in_burst;
    beat_valid = in_burst;
    beat_addr  = in_burst ? addr_q : '0;
    beat_idx   = in_burst ? idx_q : '0;
    beat_last  = is_last;
    req_err    = err_q;
  end

`ifdef BURST_ADDR_GEN_DBG_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (xfer && is_last && burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + 16'd1;
    if (err_d && err_cnt_q != '1)             err_cnt_d   = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dbg_burst_cnt = burst_cnt_q;
  assign dbg_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed bench for burst_addr_gen: vector table plus multi-cycle corner sequences.
module tb_burst_addr_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid, req_ready, abort;
  logic [7:0] req_addr;
  logic [4:0] req_len;
  logic [1:0] req_mode;
  logic [3:0] req_stride;
  logic       beat_valid, beat_ready, beat_last, busy, req_err;
  logic [7:0] beat_addr;
  logic [4:0] beat_idx;
`ifdef BURST_ADDR_GEN_DBG_CNT_EN
  logic [15:0] dbg_burst_cnt;
  logic [7:0]  dbg_err_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  burst_addr_gen #(
    .ADDR_WIDTH   (8),
    .MAX_BURST_LEN(16),
    .STRIDE_LEN   (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_mode  (req_mode),
    .req_stride(req_stride),
    .abort     (abort),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_addr (beat_addr),
    .beat_last (beat_last),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .req_err   (req_err)
`ifdef BURST_ADDR_GEN_DBG_CNT_EN
    ,
    .dbg_burst_cnt(dbg_burst_cnt),
    .dbg_err_cnt  (dbg_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] addr;
    logic [4:0] len;
    logic [3:0] stride;
    bit         err;
    int         nb;
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] alast;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] m, input logic [7:0] a, input logic [4:0] l,
                              input logic [3:0] s, input bit e, input int nb,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                              input logic [7:0] a3, input logic [7:0] al);
    vec_t v;
    v.mode = m; v.addr = a; v.len = l; v.stride = s; v.err = e; v.nb = nb;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.alast = al;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic start_req(input logic [1:0] m, input logic [7:0] a, input logic [4:0] l,
                           input logic [3:0] s);
    req_valid = 1'b1; req_mode = m; req_addr = a; req_len = l; req_stride = s;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] ea [4];
    int k;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2; ea[3] = v.a3;
    wait_ready($sformatf("v%0d", id));
    beat_ready = 1'b1;
    start_req(v.mode, v.addr, v.len, v.stride);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_err", id), req_err, 1);
      chk($sformatf("v%0d_err_valid", id), beat_valid, 0);
      chk($sformatf("v%0d_err_ready", id), req_ready, 1);
      @(negedge clk);
      chk($sformatf("v%0d_err_pulse", id), req_err, 0);
      chk($sformatf("v%0d_err_valid2", id), beat_valid, 0);
    end else begin
      k = 0;
      while (beat_valid && k < 40) begin
        if (k < 4) chk($sformatf("v%0d_addr%0d", id, k), beat_addr, ea[k]);
        chk($sformatf("v%0d_idx%0d", id, k), beat_idx, k);
        chk($sformatf("v%0d_last%0d", id, k), beat_last, (k == v.nb - 1) ? 1 : 0);
        if (k == v.nb - 1) begin
          chk($sformatf("v%0d_lastaddr", id), beat_addr, v.alast);
          chk($sformatf("v%0d_busyready", id), req_ready, 0);
        end
        @(negedge clk);
        k++;
      end
      chk($sformatf("v%0d_nbeats", id), k, v.nb);
      chk($sformatf("v%0d_ready_after", id), req_ready, 1);
    end
  endtask

  task automatic stall_seq(input logic [1:0] m, input logic [7:0] a, input logic [3:0] s,
                           input logic [7:0] e1, input logic [7:0] e2, input string tag);
    wait_ready(tag);
    beat_ready = 1'b1;
    start_req(m, a, 5'd3, s);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_b0"}, beat_addr, a);
    @(negedge clk);
    beat_ready = 1'b0;
    chk({tag, "_b1"}, beat_addr, e1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("%s_hold_valid%0d", tag, i), beat_valid, 1);
      chk($sformatf("%s_hold_addr%0d", tag, i), beat_addr, e1);
      chk($sformatf("%s_hold_idx%0d", tag, i), beat_idx, 1);
      chk($sformatf("%s_hold_last%0d", tag, i), beat_last, 0);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_b2"}, beat_addr, e2);
    chk({tag, "_b2_idx"}, beat_idx, 2);
    chk({tag, "_b2_last"}, beat_last, 1);
    @(negedge clk);
    chk({tag, "_done"}, beat_valid, 0);
  endtask

  // Abort is raised together with the request in IDLE (must be ignored),
  // then again on beat 2 while beat_ready is high (abort must win).
  task automatic abort_seq();
    wait_ready("abort");
    beat_ready = 1'b1;
    abort = 1'b1;
    start_req(2'd1, 8'h00, 5'd8, 4'd1);
    @(negedge clk);
    req_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_accept", beat_valid, 1);
    chk("abort_b0", beat_addr, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("abort_b2_idx", beat_idx, 2);
    chk("abort_b2_addr", beat_addr, 8'h02);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", beat_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", req_err, 0);
    chk("abort_ready", req_ready, 1);
    @(negedge clk);
    chk("abort_err2", req_err, 0);
    chk("abort_valid2", beat_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_mode = '0;
    req_stride = '0; abort = 1'b0; beat_ready = 1'b0;

    tv.push_back(mk(2'd1, 8'h10, 5'd4,  4'd2, 0, 4,  8'h10, 8'h12, 8'h14, 8'h16, 8'h16));
    tv.push_back(mk(2'd2, 8'h1C, 5'd4,  4'd4, 0, 4,  8'h1C, 8'h10, 8'h14, 8'h18, 8'h18));
    tv.push_back(mk(2'd1, 8'hF0, 5'd16, 4'd2, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd0, 8'h33, 5'd3,  4'd5, 0, 3,  8'h33, 8'h33, 8'h33, 8'h00, 8'h33));
    tv.push_back(mk(2'd1, 8'hF0, 5'd8,  4'd2, 0, 8,  8'hF0, 8'hF2, 8'hF4, 8'hF6, 8'hFE));
    tv.push_back(mk(2'd1, 8'hE2, 5'd16, 4'd2, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd1, 8'hE1, 5'd16, 4'd2, 0, 16, 8'hE1, 8'hE3, 8'hE5, 8'hE7, 8'hFF));
    tv.push_back(mk(2'd1, 8'h00, 5'd0,  4'd1, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd1, 8'h00, 5'd17, 4'd1, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd3, 8'h00, 5'd2,  4'd1, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd2, 8'h00, 5'd3,  4'd4, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd2, 8'h00, 5'd4,  4'd0, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd2, 8'h00, 5'd4,  4'd3, 1, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    tv.push_back(mk(2'd2, 8'hF8, 5'd16, 4'd8, 0, 16, 8'hF8, 8'h80, 8'h88, 8'h90, 8'hF0));
    tv.push_back(mk(2'd1, 8'h40, 5'd1,  4'd1, 0, 1,  8'h40, 8'h00, 8'h00, 8'h00, 8'h40));
    tv.push_back(mk(2'd2, 8'h05, 5'd2,  4'd1, 0, 2,  8'h05, 8'h04, 8'h00, 8'h00, 8'h04));
    tv.push_back(mk(2'd0, 8'hFF, 5'd16, 4'd0, 0, 16, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF));

    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", beat_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", req_err, 0);
    chk("rst_addr", beat_addr, 0);
    chk("rst_last", beat_last, 0);
    chk("rst_idx", beat_idx, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_ready", req_ready, 0);
    rstn = 1'b1;
    #1;
    chk("rst_release_ready", req_ready, 0);
    @(negedge clk);
    chk("rst_first_clk_ready", req_ready, 1);

    foreach (tv[i]) run_vec(tv[i], i);

    stall_seq(2'd0, 8'h33, 4'd1, 8'h33, 8'h33, "stall_fixed");
    stall_seq(2'd1, 8'h20, 4'd3, 8'h23, 8'h26, "stall_incr");
    abort_seq();

    // Requests presented while busy must not be taken.
    wait_ready("ignore");
    beat_ready = 1'b1;
    start_req(2'd1, 8'h00, 5'd4, 4'd1);
    @(negedge clk);
    start_req(2'd1, 8'h50, 5'd2, 4'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ignore_addr%0d", k), beat_addr, k);
      chk($sformatf("ignore_idx%0d", k), beat_idx, k);
      if (k == 3) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("ignore_valid_a", beat_valid, 0);
    @(negedge clk);
    chk("ignore_valid_b", beat_valid, 0);
    chk("ignore_err", req_err, 0);

    // Reset asserted mid-burst clears outputs without waiting for a clock.
    wait_ready("rstmid");
    beat_ready = 1'b1;
    start_req(2'd1, 8'h80, 5'd8, 4'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_busy0", busy, 0);
    chk("rstmid_valid0", beat_valid, 0);
    chk("rstmid_addr0", beat_addr, 0);
    chk("rstmid_idx0", beat_idx, 0);
    chk("rstmid_last0", beat_last, 0);
    chk("rstmid_ready0", req_ready, 0);
    chk("rstmid_err0", req_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rstmid_rel_ready", req_ready, 0);
    @(negedge clk);
    chk("rstmid_ready1", req_ready, 1);
    chk("rstmid_valid_after", beat_valid, 0);

`ifdef BURST_ADDR_GEN_DBG_CNT_EN
    rstn = 1'b0;
    #1;
    chk("dbg_rst_burst", dbg_burst_cnt, 0);
    chk("dbg_rst_err", dbg_err_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_vec(tv[0], 100);
    run_vec(tv[1], 101);
    abort_seq();
    run_vec(tv[2], 102);
    chk("dbg_burst_cnt", dbg_burst_cnt, 2);
    chk("dbg_err_cnt", dbg_err_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
